// File: rtl/auth_msg_tx_port.sv
// auth_msg_tx_port
// Controller-side transmit port for authentication messages. One message is
// latched from the auth core, presented on auth_msg_out with a PD/DEBUG strobe,
// and retried on ack timeout. Completion is reported via tx_done or tx_error.
// The port then waits for the driver's level ack to fall before it accepts
// another message.
module auth_msg_tx_port #(
  parameter int MSG_LEN     = 2048,
  parameter int ACK_TIMEOUT = 64,
  parameter int MAX_RETRY   = 3,
  parameter int GAP_CYCLES  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_valid,
  input  logic [MSG_LEN-1:0] tx_msg,
  input  logic               tx_dest,
  input  logic               tx_expect_resp,
  output logic               tx_ready,
  output logic [MSG_LEN-1:0] auth_msg_out,
  output logic               auth_msg_ready,
  output logic               PD_ready,
  output logic               DEBUG_ready,
  input  logic               Ack_in_driver,
  output logic               resp_req_out,
  output logic               tx_done,
  output logic               tx_error
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_GAP     = 2'd2,
    S_ACK_CLR = 2'd3
  } state_e;

  state_e             state_q;
  logic [MSG_LEN-1:0] msg_q;
  logic               dest_q;
  logic               resp_q;
  logic [TW-1:0]      tmo_q;
  logic [RW-1:0]      retry_q;
  logic [GW-1:0]      gap_q;
  logic               tx_ready_q;
  logic               ready_q;
  logic               pd_q;
  logic               dbg_q;
  logic               resp_req_q;
  logic               done_q;
  logic               err_q;

  assign tx_ready       = tx_ready_q;
  assign auth_msg_out   = msg_q;
  assign auth_msg_ready = ready_q;
  assign PD_ready       = pd_q;
  assign DEBUG_ready    = dbg_q;
  assign resp_req_out   = resp_req_q;
  assign tx_done        = done_q;
  assign tx_error       = err_q;

  // Transmit FSM: all outputs registered; the pulse outputs default low every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      msg_q      <= '0;
      dest_q     <= 1'b0;
      resp_q     <= 1'b0;
      tmo_q      <= '0;
      retry_q    <= '0;
      gap_q      <= '0;
      tx_ready_q <= 1'b0;
      ready_q    <= 1'b0;
      pd_q       <= 1'b0;
      dbg_q      <= 1'b0;
      resp_req_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      resp_req_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // tx_ready_q is low only in the first cycle after reset release.
          if (tx_valid && tx_ready_q) begin
            msg_q      <= tx_msg;
            dest_q     <= tx_dest;
            resp_q     <= tx_expect_resp;
            retry_q    <= '0;
            tmo_q      <= '0;
            ready_q    <= 1'b1;
            pd_q       <= ~tx_dest;
            dbg_q      <= tx_dest;
            tx_ready_q <= 1'b0;
            state_q    <= S_SEND;
          end else begin
            tx_ready_q <= 1'b1;
          end
        end
        S_SEND: begin
          // An ack on the timeout edge still wins.
          if (Ack_in_driver) begin
            ready_q    <= 1'b0;
            pd_q       <= 1'b0;
            dbg_q      <= 1'b0;
            done_q     <= 1'b1;
            resp_req_q <= resp_q;
            state_q    <= S_ACK_CLR;
          end else if (tmo_q == TMO_LAST) begin
            ready_q <= 1'b0;
            pd_q    <= 1'b0;
            dbg_q   <= 1'b0;
            if (retry_q < RETRY_MAX) begin
              retry_q <= retry_q + RW'(1);
              gap_q   <= '0;
              state_q <= S_GAP;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_ACK_CLR;
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_GAP: begin
          // Ack is deliberately not looked at here: a late ack is not credited.
          if (gap_q == GAP_LAST) begin
            tmo_q   <= '0;
            ready_q <= 1'b1;
            pd_q    <= ~dest_q;
            dbg_q   <= dest_q;
            state_q <= S_SEND;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        S_ACK_CLR: begin
          // A stale level ack must not acknowledge the next message.
          if (!Ack_in_driver) begin
            tx_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            tx_ready_q <= 1'b0;
          end
        end
        default: begin
          ready_q    <= 1'b0;
          pd_q       <= 1'b0;
          dbg_q      <= 1'b0;
          tx_ready_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_auth_msg_tx_port.sv
// Testbench for auth_msg_tx_port: a scenario task per feature; the expected
// completions are queued when a message is offered and popped when the DUT
// reports tx_done or tx_error.
module tb_auth_msg_tx_port;

  localparam int MSG_LEN     = 2048;
  localparam int ACK_TIMEOUT = 64;
  localparam int MAX_RETRY   = 3;
  localparam int GAP_CYCLES  = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               tx_valid;
  logic [MSG_LEN-1:0] tx_msg;
  logic               tx_dest;
  logic               tx_expect_resp;
  logic               tx_ready;
  logic [MSG_LEN-1:0] auth_msg_out;
  logic               auth_msg_ready;
  logic               PD_ready;
  logic               DEBUG_ready;
  logic               Ack_in_driver;
  logic               resp_req_out;
  logic               tx_done;
  logic               tx_error;

  typedef struct {
    logic               is_err;
    logic               resp;
    logic [MSG_LEN-1:0] msg;
  } exp_t;

  exp_t exp_q[$];
  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  always #5 clk = ~clk;

  auth_msg_tx_port #(
    .MSG_LEN(MSG_LEN), .ACK_TIMEOUT(ACK_TIMEOUT),
    .MAX_RETRY(MAX_RETRY), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_msg(tx_msg),
    .tx_dest(tx_dest), .tx_expect_resp(tx_expect_resp), .tx_ready(tx_ready),
    .auth_msg_out(auth_msg_out), .auth_msg_ready(auth_msg_ready),
    .PD_ready(PD_ready), .DEBUG_ready(DEBUG_ready), .Ack_in_driver(Ack_in_driver),
    .resp_req_out(resp_req_out), .tx_done(tx_done), .tx_error(tx_error)
  );

  // Pulse counting and the destination-strobe rule, sampled on the falling edge.
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (auth_msg_ready || PD_ready || DEBUG_ready) begin
      total++;
      if (!(auth_msg_ready && (PD_ready ^ DEBUG_ready))) begin
        bad++;
        $display("FAIL strobe_rule: ready=%0b pd=%0b dbg=%0b, required ready=1 with exactly one strobe",
                 auth_msg_ready, PD_ready, DEBUG_ready);
      end
    end
  end

  task automatic wait_tx_ready(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_msg_ready(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (auth_msg_ready === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_fin(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1 || tx_error === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // Offer one message and queue its expected outcome; returns just after acceptance.
  task automatic send(input logic [MSG_LEN-1:0] m, input logic d, input logic r, input logic will_err);
    bit ok;
    exp_t e;
    wait_tx_ready(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL send_tx_ready: tx_ready=%0b, required 1", tx_ready); end
    tx_msg = m; tx_dest = d; tx_expect_resp = r; tx_valid = 1'b1;
    e.is_err = will_err; e.resp = r; e.msg = m;
    exp_q.push_back(e);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; tx_valid = 1'b0; tx_msg = '0; tx_dest = 1'b0;
    tx_expect_resp = 1'b0; Ack_in_driver = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({tx_ready, auth_msg_ready, PD_ready, DEBUG_ready, resp_req_out, tx_done, tx_error} !== 7'b0) begin
      bad++; $display("FAIL reset_outputs: got %b, required 0000000",
                      {tx_ready, auth_msg_ready, PD_ready, DEBUG_ready, resp_req_out, tx_done, tx_error});
    end
    total++;
    if (auth_msg_out !== '0) begin bad++; $display("FAIL reset_msg: got %h, required 0", auth_msg_out[31:0]); end
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready: got %b, required 1", tx_ready); end
  endtask

  task automatic test_pd_ack();
    logic [MSG_LEN-1:0] m;
    bit ok;
    exp_t e;
    m = {256{8'hA5}};
    done_cnt = 0; err_cnt = 0;
    send(m, 1'b0, 1'b0, 1'b0);
    wait_msg_ready(10, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL pd_msg_ready: auth_msg_ready=%0b, required 1", auth_msg_ready); end
    total++;
    if ({PD_ready, DEBUG_ready} !== 2'b10) begin bad++; $display("FAIL pd_strobe: got %b, required 10", {PD_ready, DEBUG_ready}); end
    total++;
    if (tx_ready !== 1'b0) begin bad++; $display("FAIL pd_busy: tx_ready=%b, required 0", tx_ready); end
    @(posedge clk); #1 Ack_in_driver = 1'b1;
    wait_fin(10, ok);
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++; $display("FAIL pd_finish: done=%0b err=%0b queued=%0d, required a completion", tx_done, tx_error, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      total++;
      if ({tx_done, tx_error, resp_req_out} !== {~e.is_err, e.is_err, e.resp & ~e.is_err}) begin
        bad++; $display("FAIL pd_pulses: done/err/resp=%b, required %b", {tx_done, tx_error, resp_req_out},
                        {~e.is_err, e.is_err, e.resp & ~e.is_err});
      end
      total++;
      if (auth_msg_out !== e.msg) begin bad++; $display("FAIL pd_msg: got %h, required %h", auth_msg_out[31:0], e.msg[31:0]); end
    end
    @(negedge clk);
    total++;
    if ({tx_done, auth_msg_ready, tx_ready} !== 3'b000) begin
      bad++; $display("FAIL pd_ack_clr: done/ready/tx_ready=%b, required 000", {tx_done, auth_msg_ready, tx_ready});
    end
    @(posedge clk); #1 Ack_in_driver = 1'b0;
    wait_tx_ready(10, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL pd_tx_ready_back: tx_ready=%b, required 1", tx_ready); end
    total++;
    if (done_cnt !== 1 || err_cnt !== 0) begin bad++; $display("FAIL pd_counts: done=%0d err=%0d, required 1 0", done_cnt, err_cnt); end
    total++;
    if (auth_msg_out !== m) begin bad++; $display("FAIL pd_msg_hold: got %h, required %h", auth_msg_out[31:0], m[31:0]); end
  endtask

  task automatic test_debug_resp();
    logic [MSG_LEN-1:0] m;
    bit ok;
    exp_t e;
    m = {64{32'hDEADBEEF}};
    send(m, 1'b1, 1'b1, 1'b0);
    wait_msg_ready(10, ok);
    total++;
    if (!ok || {PD_ready, DEBUG_ready} !== 2'b01) begin
      bad++; $display("FAIL dbg_strobe: ready=%0b pd/dbg=%b, required 1 01", auth_msg_ready, {PD_ready, DEBUG_ready});
    end
    @(posedge clk); #1 Ack_in_driver = 1'b1;
    wait_fin(10, ok);
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++; $display("FAIL dbg_finish: done=%0b err=%0b queued=%0d, required a completion", tx_done, tx_error, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      total++;
      if ({tx_done, tx_error, resp_req_out} !== {~e.is_err, e.is_err, e.resp & ~e.is_err}) begin
        bad++; $display("FAIL dbg_pulses: done/err/resp=%b, required %b", {tx_done, tx_error, resp_req_out},
                        {~e.is_err, e.is_err, e.resp & ~e.is_err});
      end
      total++;
      if (auth_msg_out !== e.msg) begin bad++; $display("FAIL dbg_msg: got %h, required %h", auth_msg_out[31:0], e.msg[31:0]); end
    end
    @(negedge clk);
    total++;
    if ({resp_req_out, tx_done} !== 2'b00) begin bad++; $display("FAIL dbg_one_cycle: resp/done=%b, required 00", {resp_req_out, tx_done}); end
    @(posedge clk); #1 Ack_in_driver = 1'b0;
    wait_tx_ready(10, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL dbg_tx_ready_back: tx_ready=%b, required 1", tx_ready); end
  endtask

  task automatic test_timeout();
    logic [MSG_LEN-1:0] m;
    bit ok;
    exp_t e;
    int attempts;
    int run;
    logic lvl;
    for (int i = 0; i < MSG_LEN / 32; i++) m[i*32 +: 32] = $urandom;
    done_cnt = 0; err_cnt = 0; attempts = 0; run = 0; lvl = 1'b0; ok = 1'b0;
    send(m, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (auth_msg_ready !== lvl) begin
        if (lvl) begin
          total++;
          if (run != ACK_TIMEOUT) begin bad++; $display("FAIL tmo_attempt_len: got %0d, required %0d", run, ACK_TIMEOUT); end
        end else if (attempts > 0) begin
          total++;
          if (run != GAP_CYCLES) begin bad++; $display("FAIL tmo_gap_len: got %0d, required %0d", run, GAP_CYCLES); end
        end
        if (auth_msg_ready) attempts++;
        lvl = auth_msg_ready; run = 0;
      end
      run++;
      if (tx_done || tx_error) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++; $display("FAIL tmo_finish: done=%0b err=%0b queued=%0d, required a completion", tx_done, tx_error, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      total++;
      if ({tx_done, tx_error, resp_req_out} !== {~e.is_err, e.is_err, e.resp & ~e.is_err}) begin
        bad++; $display("FAIL tmo_pulses: done/err/resp=%b, required %b", {tx_done, tx_error, resp_req_out},
                        {~e.is_err, e.is_err, e.resp & ~e.is_err});
      end
    end
    total++;
    if (attempts != MAX_RETRY + 1) begin bad++; $display("FAIL tmo_attempts: got %0d, required %0d", attempts, MAX_RETRY + 1); end
    repeat (3) @(negedge clk);
    total++;
    if (err_cnt !== 1 || done_cnt !== 0) begin bad++; $display("FAIL tmo_counts: err=%0d done=%0d, required 1 0", err_cnt, done_cnt); end
    total++;
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL tmo_tx_ready_back: got %b, required 1", tx_ready); end
  endtask

  task automatic test_retry_ack();
    logic [MSG_LEN-1:0] m;
    bit ok;
    exp_t e;
    int attempts;
    int run;
    logic lvl;
    m = {128{16'h3C96}};
    done_cnt = 0; err_cnt = 0; attempts = 0; run = 0; lvl = 1'b0; ok = 1'b0;
    send(m, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (auth_msg_ready !== lvl) begin
        if (auth_msg_ready) attempts++;
        lvl = auth_msg_ready; run = 0;
      end
      run++;
      if (tx_done || tx_error) begin ok = 1'b1; break; end
      // Ack pulse landing on the first GAP edge must be ignored.
      if (attempts == 1 && !lvl && run == 1) Ack_in_driver = 1'b1;
      else if (attempts == 1 && !lvl && run == 2) Ack_in_driver = 1'b0;
      if (attempts == 3 && lvl && run == 5) Ack_in_driver = 1'b1;
    end
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++; $display("FAIL retry_finish: done=%0b err=%0b queued=%0d, required a completion", tx_done, tx_error, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      total++;
      if ({tx_done, tx_error, resp_req_out} !== {~e.is_err, e.is_err, e.resp & ~e.is_err}) begin
        bad++; $display("FAIL retry_pulses: done/err/resp=%b, required %b", {tx_done, tx_error, resp_req_out},
                        {~e.is_err, e.is_err, e.resp & ~e.is_err});
      end
    end
    total++;
    if (attempts != 3) begin bad++; $display("FAIL retry_attempts: got %0d, required 3", attempts); end
    @(posedge clk); #1 Ack_in_driver = 1'b0;
    wait_tx_ready(10, ok);
    total++;
    if (!ok || err_cnt !== 0 || done_cnt !== 1) begin
      bad++; $display("FAIL retry_counts: tx_ready=%b err=%0d done=%0d, required 1 0 1", tx_ready, err_cnt, done_cnt);
    end
  endtask

  task automatic test_ack_at_timeout();
    logic [MSG_LEN-1:0] m;
    bit ok;
    exp_t e;
    int hi;
    m = {32{64'h0123456789ABCDEF}};
    done_cnt = 0; err_cnt = 0; hi = 0;
    send(m, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (auth_msg_ready) hi++;
      if (hi == ACK_TIMEOUT) begin Ack_in_driver = 1'b1; break; end
    end
    wait_fin(1, ok);
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++; $display("FAIL prio_finish: done=%0b err=%0b, required ack on the timeout edge", tx_done, tx_error);
    end else begin
      e = exp_q.pop_front();
      total++;
      if ({tx_done, tx_error, resp_req_out} !== {~e.is_err, e.is_err, e.resp & ~e.is_err}) begin
        bad++; $display("FAIL prio_pulses: done/err/resp=%b, required %b", {tx_done, tx_error, resp_req_out},
                        {~e.is_err, e.is_err, e.resp & ~e.is_err});
      end
    end
    @(posedge clk); #1 Ack_in_driver = 1'b0;
    wait_tx_ready(10, ok);
    total++;
    if (!ok || done_cnt !== 1 || err_cnt !== 0) begin
      bad++; $display("FAIL prio_counts: tx_ready=%b done=%0d err=%0d, required 1 1 0", tx_ready, done_cnt, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [MSG_LEN-1:0] ma;
    logic [MSG_LEN-1:0] mb;
    bit ok;
    exp_t e;
    ma = {256{8'h5A}};
    for (int i = 0; i < MSG_LEN / 32; i++) mb[i*32 +: 32] = $urandom;
    send(ma, 1'b0, 1'b0, 1'b0);
    wait_msg_ready(10, ok);
    @(posedge clk); #1 Ack_in_driver = 1'b1;
    wait_fin(10, ok);
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++; $display("FAIL b2b_first_finish: done=%0b err=%0b, required a completion", tx_done, tx_error);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (tx_done !== 1'b1 || auth_msg_out !== e.msg) begin
        bad++; $display("FAIL b2b_first: done=%b msg=%h, required 1 %h", tx_done, auth_msg_out[31:0], e.msg[31:0]);
      end
    end
    tx_msg = mb; tx_dest = 1'b1; tx_expect_resp = 1'b1; tx_valid = 1'b1;
    e.is_err = 1'b0; e.resp = 1'b1; e.msg = mb;
    exp_q.push_back(e);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (tx_ready !== 1'b0 || auth_msg_ready !== 1'b0) begin
        bad++; $display("FAIL b2b_held: tx_ready=%b ready=%b, required 0 0", tx_ready, auth_msg_ready);
      end
    end
    @(posedge clk); #1 Ack_in_driver = 1'b0;
    wait_msg_ready(10, ok);
    tx_valid = 1'b0;
    total++;
    if (!ok || auth_msg_out !== mb || {PD_ready, DEBUG_ready} !== 2'b01) begin
      bad++; $display("FAIL b2b_second_send: ready=%b msg=%h pd/dbg=%b, required 1 %h 01",
                      auth_msg_ready, auth_msg_out[31:0], {PD_ready, DEBUG_ready}, mb[31:0]);
    end
    @(posedge clk); #1 Ack_in_driver = 1'b1;
    wait_fin(10, ok);
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++; $display("FAIL b2b_second_finish: done=%0b err=%0b, required a completion", tx_done, tx_error);
    end else begin
      e = exp_q.pop_front();
      total++;
      if ({tx_done, tx_error, resp_req_out} !== {~e.is_err, e.is_err, e.resp & ~e.is_err} || auth_msg_out !== e.msg) begin
        bad++; $display("FAIL b2b_second: done/err/resp=%b msg=%h, required %b %h", {tx_done, tx_error, resp_req_out},
                        auth_msg_out[31:0], {~e.is_err, e.is_err, e.resp & ~e.is_err}, e.msg[31:0]);
      end
    end
    @(posedge clk); #1 Ack_in_driver = 1'b0;
    wait_tx_ready(10, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_tx_ready_back: tx_ready=%b, required 1", tx_ready); end
  endtask

  task automatic test_reset_mid_send();
    logic [MSG_LEN-1:0] m;
    bit ok;
    m = {64{32'hCAFEF00D}};
    send(m, 1'b1, 1'b1, 1'b0);
    wait_msg_ready(10, ok);
    repeat (10) @(negedge clk);
    err_cnt = 0;
    #2 reset = 1'b0;
    #1;
    total++;
    if ({tx_ready, auth_msg_ready, PD_ready, DEBUG_ready, resp_req_out, tx_done, tx_error} !== 7'b0 || auth_msg_out !== '0) begin
      bad++; $display("FAIL rst_async: outs=%b msg=%h, required 0000000 0",
                      {tx_ready, auth_msg_ready, PD_ready, DEBUG_ready, resp_req_out, tx_done, tx_error}, auth_msg_out[31:0]);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (tx_ready !== 1'b1 || auth_msg_ready !== 1'b0 || err_cnt !== 0) begin
      bad++; $display("FAIL rst_recover: tx_ready=%b ready=%b err=%0d, required 1 0 0", tx_ready, auth_msg_ready, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_pd_ack();
    test_debug_resp();
    test_timeout();
    test_retry_ack();
    test_ack_at_timeout();
    test_back_to_back();
    test_reset_mid_send();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_empty: %0d left, required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
